// File: rtl/fifo_read_stream.sv
// fifo_read_stream: drains a fixed-latency FIFO read port into a valid/ready stream.
// Define OUT_LAST_EN to add out_last, asserted on every PACKET_LEN-th beat.
module fifo_read_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int PACKET_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef OUT_LAST_EN
    ,
    output logic                  out_last
`endif
);
    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [OW-1:0] O_ONE = OW'(1);
    localparam logic [OW:0] O_DEPTH = (OW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(BUF_DEPTH - 1);

    if (READ_LATENCY < 1 || PACKET_LEN < 1) begin : g_param_check
        $error("fifo_read_stream: READ_LATENCY and PACKET_LEN must be at least 1");
    end

    logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];
    logic [PW-1:0]           r_wr;
    logic [PW-1:0]           r_rd;
    logic [OW-1:0]           r_occ;
    logic [OW-1:0]           r_infl;
    logic [READ_LATENCY-1:0] r_track;
    logic                    w_cap;
    logic                    w_fire;

    assign w_cap = r_track[READ_LATENCY-1];
    assign w_fire = out_valid && out_ready;
    // Reads are throttled so every word in flight is guaranteed a free slot on arrival.
    assign fifo_read = !reset && !fifo_empty && ({1'b0, r_infl} + {1'b0, r_occ} < O_DEPTH);
    assign out_valid = r_occ != '0;
    assign out_data = r_buf[r_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_occ <= '0;
            r_infl <= '0;
            r_track <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_track <= READ_LATENCY'({r_track, fifo_read});
            r_infl <= fifo_read == w_cap ? r_infl : (fifo_read ? r_infl + O_ONE : r_infl - O_ONE);
            r_occ <= w_cap == w_fire ? r_occ : (w_cap ? r_occ + O_ONE : r_occ - O_ONE);
            if (w_cap) begin
                r_buf[r_wr] <= fifo_read_data;
                r_wr <= r_wr == P_LAST ? '0 : r_wr + P_ONE;
            end
            if (w_fire) r_rd <= r_rd == P_LAST ? '0 : r_rd + P_ONE;
        end
    end

`ifdef OUT_LAST_EN
    localparam int CW = $clog2(PACKET_LEN + 1);
    localparam logic [CW-1:0] C_LAST = CW'(PACKET_LEN - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [CW-1:0] r_cnt;

    assign out_last = out_valid && r_cnt == C_LAST;

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else if (w_fire) r_cnt <= r_cnt == C_LAST ? '0 : r_cnt + C_ONE;
    end
`endif
endmodule

// File: tb/tb_fifo_read_stream.sv
// tb_fifo_read_stream: two lanes (READ_LATENCY 1 and 3) fed from queue-based FIFO models;
// words are scoreboarded in push order and checked by a per-lane monitor.
module tb_fifo_read_stream;
    logic clk = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic void chk(int g, string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL lane%0d %s: got %0h, want %0h", g, nm, got, want);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int RL = g == 0 ? 1 : 3;
        localparam int PKT = 4;
        logic rst, fifo_empty, fifo_read, out_valid, out_ready;
        logic [7:0] fifo_read_data, out_data;
`ifdef OUT_LAST_EN
        logic out_last;
`endif
        logic [7:0] pipe [RL];
        logic [7:0] fq[$];
        logic [7:0] exp_q[$];
        int outst = 0;
        int beats = 0;
        int pct = 100;
        logic s_rd, s_v, s_e;
        logic [7:0] s_d;
        logic fin = 1'b0;

        fifo_read_stream #(.DATA_WIDTH(8), .READ_LATENCY(RL), .PACKET_LEN(PKT)) dut (
            .clk(clk),
            .reset(rst),
            .fifo_empty(fifo_empty),
            .fifo_read(fifo_read),
            .fifo_read_data(fifo_read_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data(out_data)
`ifdef OUT_LAST_EN
            ,
            .out_last(out_last)
`endif
        );

        task automatic push(input logic [7:0] w);
            fq.push_back(w);
            exp_q.push_back(w);
            fifo_empty = 1'b0;
        endtask

        // One clock: sample at negedge, then model the FIFO pop and read-data pipeline after posedge.
        task automatic tick;
            logic rd, fv, rs;
            @(negedge clk);
            rd = fifo_read;
            fv = out_valid && out_ready && !rst;
            rs = rst;
            s_rd = rd;
            s_v = out_valid;
            s_d = out_data;
            s_e = fifo_empty;
            if (rd) chk(g, "read_while_empty", int'(s_e), 0);
            @(posedge clk);
            #1;
            for (int k = RL - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = rd && fq.size() > 0 ? fq.pop_front() : 8'($urandom);
            outst += int'(rd) - int'(fv);
            if (rs) begin
                while (outst > 0 && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    outst--;
                end
                outst = 0;
            end
            chk(g, "outstanding_bound", int'(outst <= RL + 2), 1);
            fifo_read_data = pipe[RL-1];
            fifo_empty = fq.size() == 0;
            out_ready = $urandom_range(99) < pct;
        endtask

        task automatic window(input int n, output int rf, rc, rl, vf, vc, vl, output logic [7:0] df);
            rf = -1; rc = 0; rl = -1; vf = -1; vc = 0; vl = -1; df = 8'h00;
            for (int c = 0; c < n; c++) begin
                tick();
                if (s_rd) begin
                    if (rf < 0) rf = c;
                    rl = c;
                    rc++;
                end
                if (s_v) begin
                    if (vf < 0) begin
                        vf = c;
                        df = s_d;
                    end
                    vl = c;
                    vc++;
                end
            end
        endtask

        task automatic drain;
            pct = 100;
            out_ready = 1'b1;
            for (int c = 0; c < 80 && exp_q.size() > 0; c++) tick();
            repeat (RL + 3) tick();
        endtask

        initial begin
            logic hold;
            logic [7:0] hold_d;
            hold = 1'b0;
            hold_d = 8'h00;
            forever begin
                @(negedge clk);
                if (rst) beats = 0;
                else begin
                    if (hold) chk(g, "stall_stable", int'({out_valid, out_data}), int'({1'b1, hold_d}));
`ifdef OUT_LAST_EN
                    chk(g, "out_last", int'(out_last), int'(out_valid && beats % PKT == PKT - 1));
`endif
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) chk(g, "extra_beat", 1, 0);
                        else chk(g, "data", int'(out_data), int'(exp_q.pop_front()));
                        beats++;
                    end
                end
                hold = !rst && out_valid && !out_ready;
                hold_d = out_data;
            end
        end

        initial begin
            int rf, rc, rl, vf, vc, vl;
            logic [7:0] df;
            rst = 1'b1;
            fifo_empty = 1'b1;
            fifo_read_data = 8'h00;
            out_ready = 1'b1;
            for (int k = 0; k < RL; k++) pipe[k] = 8'h00;
            for (int i = 1; i <= 8; i++) push(8'(i));
            repeat (2) begin
                tick();
                chk(g, "reset_read", int'(s_rd), 0);
                chk(g, "reset_valid", int'(s_v), 0);
                chk(g, "reset_data", int'(s_d), 0);
            end
            rst = 1'b0;
            window(RL + 12, rf, rc, rl, vf, vc, vl, df);
            chk(g, "burst_read_first", rf, 0);
            chk(g, "burst_read_count", rc, 8);
            chk(g, "burst_read_last", rl, 7);
            chk(g, "burst_valid_first", vf, RL + 1);
            chk(g, "burst_valid_count", vc, 8);
            chk(g, "burst_valid_last", vl, RL + 8);
            chk(g, "burst_first_data", int'(df), 1);
            chk(g, "burst_drained", exp_q.size(), 0);
            for (int i = 1; i <= 8; i++) push(8'(i));
            pct = 0;
            out_ready = 1'b0;
            window(RL + 10, rf, rc, rl, vf, vc, vl, df);
            chk(g, "stall_read_count", rc, RL + 2);
            chk(g, "stall_valid", int'(s_v), 1);
            chk(g, "stall_data", int'(s_d), 1);
            pct = 100;
            out_ready = 1'b1;
            window(RL + 12, rf, rc, rl, vf, vc, vl, df);
            chk(g, "resume_valid_first", vf, 0);
            chk(g, "resume_valid_count", vc, 8);
            chk(g, "resume_drained", exp_q.size(), 0);
            window(20, rf, rc, rl, vf, vc, vl, df);
            chk(g, "empty_reads", rc, 0);
            push(8'hA5);
            window(RL + 4, rf, rc, rl, vf, vc, vl, df);
            chk(g, "single_read_first", rf, 0);
            chk(g, "single_read_count", rc, 1);
            chk(g, "single_valid_first", vf, RL + 1);
            chk(g, "single_data", int'(df), 8'hA5);
            for (int i = 0; i < 32; i++) push(8'($urandom));
            window(RL + 36, rf, rc, rl, vf, vc, vl, df);
            chk(g, "stream_valid_first", vf, RL + 1);
            chk(g, "stream_valid_count", vc, 32);
            chk(g, "stream_valid_last", vl, RL + 32);
            pct = 60;
            repeat (400) begin
                if ($urandom_range(99) < 40) push(8'($urandom));
                tick();
            end
            drain();
            chk(g, "random_drained", exp_q.size(), 0);
            for (int i = 1; i <= 8; i++) push(8'(8'h10 + i));
            window(RL + 3, rf, rc, rl, vf, vc, vl, df);
            rst = 1'b1;
            tick();
            chk(g, "midreset_read", int'(s_rd), 0);
            rst = 1'b0;
            tick();
            chk(g, "post_reset_valid", int'(s_v), 0);
            drain();
            chk(g, "post_reset_drained", exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && !(lane[0].fin && lane[1].fin); c++) @(posedge clk);
        if (!(lane[0].fin && lane[1].fin)) begin
            n_bad++;
            $display("FAIL timeout: lanes done %b%b, want 11", lane[1].fin, lane[0].fin);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
